// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, LFSR taps and sequence arithmetic for the UART test-pattern source.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_DONE,
        ST_WAIT_ECHO,
        ST_GAP,
        ST_FINISH
    } state_e;

    typedef enum logic [1:0] {
        MODE_INC  = 2'd0,
        MODE_DEC  = 2'd1,
        MODE_WALK = 2'd2,
        MODE_LFSR = 2'd3
    } mode_e;

    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

    // Walking-one and LFSR lock up on an all-zero word, so a zero seed becomes 1.
    function automatic logic [15:0] first_word(input mode_e m, input logic [15:0] s);
        if ((m == MODE_WALK || m == MODE_LFSR) && s == 16'h0000)
            return 16'h0001;
        return s;
    endfunction

    function automatic logic [15:0] next_word(input mode_e m, input logic [15:0] w, input logic wide);
        logic [15:0] r;
        case (m)
            MODE_INC:  r = w + 16'd1;
            MODE_DEC:  r = w - 16'd1;
            MODE_WALK: r = wide ? {w[14:0], w[15]} : {8'h00, w[6:0], w[7]};
            default:   r = wide ? ({1'b0, w[15:1]} ^ (w[0] ? LFSR_TAPS_16 : 16'h0000))
                                : {8'h00, {1'b0, w[7:1]} ^ (w[0] ? LFSR_TAPS_8 : 8'h00)};
        endcase
        return wide ? r : {8'h00, r[7:0]};
    endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// rtl/uart_gap_timer.sv - loadable down-counter shared by the inter-word gap and the echo timeout.
module uart_gap_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/uart_tx_pattern_gen.sv
// rtl/uart_tx_pattern_gen.sv - burst test-pattern source for the UART TX core.
// Define RX_ECHO_CHECK_EN to compare the RX loop-back echo and count mismatches/timeouts.
module uart_tx_pattern_gen
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int BURST_LEN    = 16,
    parameter int GAP_CYCLES   = 0,
    parameter int ECHO_TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    output logic              tx_dv,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_done,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              burst_done,
    output logic [15:0]       word_cnt,
    output logic [15:0]       err_cnt
);

    localparam logic WIDE    = (DATA_W == 16);
    localparam int   TMR_MAX = (ECHO_TIMEOUT > GAP_CYCLES) ? ECHO_TIMEOUT : GAP_CYCLES;
    localparam int   TW      = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
    // Timer reaches zero after load_val further clocks, so load one less than the dwell.
    localparam logic [TW-1:0] GAP_LOAD = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e            state;
    mode_e             mode_q;
    logic              stop_q;
    logic              tmr_load;
    logic              tmr_en;
    logic              tmr_zero;
    logic [TW-1:0]     tmr_val;
    logic [DATA_W-1:0] nxt_word;
    logic              last_word;

    assign nxt_word  = DATA_W'(next_word(mode_q, 16'(tx_data), WIDE));
    assign last_word = (BURST_LEN != 0) && (word_cnt == 16'(BURST_LEN));
    assign tmr_en    = (state == ST_GAP) || (state == ST_WAIT_ECHO);

`ifdef RX_ECHO_CHECK_EN
    localparam logic [TW-1:0] ECHO_LOAD = TW'((ECHO_TIMEOUT > 0) ? ECHO_TIMEOUT - 1 : 0);
    logic [15:0] err_q;
    assign err_cnt = err_q;
`else
    logic unused_rx;
    assign unused_rx = ^{rx_valid, rx_data};
    assign err_cnt   = 16'h0000;
`endif

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = GAP_LOAD;
        if (state == ST_WAIT_DONE && tx_done) begin
            tmr_load = 1'b1;
`ifdef RX_ECHO_CHECK_EN
            tmr_val  = ECHO_LOAD;
`endif
        end
`ifdef RX_ECHO_CHECK_EN
        if (state == ST_WAIT_ECHO && (rx_valid || tmr_zero))
            tmr_load = 1'b1;
`endif
    end

    uart_gap_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_INC;
            stop_q     <= 1'b0;
            tx_dv      <= 1'b0;
            tx_data    <= '0;
            busy       <= 1'b0;
            burst_done <= 1'b0;
            word_cnt   <= 16'h0000;
`ifdef RX_ECHO_CHECK_EN
            err_q      <= 16'h0000;
`endif
        end else begin
            tx_dv      <= 1'b0;
            burst_done <= 1'b0;
            // stop is a level but may drop before the word finishes; remember it.
            if (state != ST_IDLE && stop)
                stop_q <= 1'b1;
            case (state)
                ST_IDLE: if (start) begin
                    mode_q   <= mode_e'(mode);
                    tx_data  <= DATA_W'(first_word(mode_e'(mode), 16'(seed)));
                    word_cnt <= 16'h0000;
`ifdef RX_ECHO_CHECK_EN
                    err_q    <= 16'h0000;
`endif
                    stop_q   <= 1'b0;
                    busy     <= 1'b1;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    tx_dv <= 1'b1;
                    state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: if (tx_done) begin
                    word_cnt <= word_cnt + 16'd1;
`ifdef RX_ECHO_CHECK_EN
                    state    <= ST_WAIT_ECHO;
`else
                    state    <= ST_GAP;
`endif
                end
`ifdef RX_ECHO_CHECK_EN
                ST_WAIT_ECHO: if (rx_valid || tmr_zero) begin
                    // An echo landing on the timeout cycle still counts as an echo.
                    if ((!rx_valid || rx_data != tx_data) && err_q != 16'hFFFF)
                        err_q <= err_q + 16'd1;
                    state <= ST_GAP;
                end
`endif
                ST_GAP: if (tmr_zero) begin
                    tx_data <= nxt_word;
                    if (last_word || stop || stop_q) begin
                        burst_done <= 1'b1;
                        state      <= ST_FINISH;
                    end else begin
                        state <= ST_SEND;
                    end
                end
                ST_FINISH: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_pattern_gen.sv
// tb/tb_uart_tx_pattern_gen.sv - directed self-checking bench for uart_tx_pattern_gen.
module tb_uart_tx_pattern_gen;

    localparam int DW  = 8;
    localparam int BL  = 4;
    localparam int GAP = 5;
    localparam int ETO = 50;
`ifdef RX_ECHO_CHECK_EN
    localparam int ECHO_LAT = 1;
`else
    localparam int ECHO_LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          tx_done = 1'b0;
    logic          rx_valid = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [DW-1:0] seed = '0;
    logic [DW-1:0] rx_data = '0;
    logic          tx_dv;
    logic          busy;
    logic          burst_done;
    logic [DW-1:0] tx_data;
    logic [15:0]   word_cnt;
    logic [15:0]   err_cnt;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int dv_cnt = 0;
    int bd_cnt = 0;
    int last_m = 0;

    uart_tx_pattern_gen #(
        .DATA_W       (DW),
        .BURST_LEN    (BL),
        .GAP_CYCLES   (GAP),
        .ECHO_TIMEOUT (ETO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .seed       (seed),
        .tx_dv      (tx_dv),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .busy       (busy),
        .burst_done (burst_done),
        .word_cnt   (word_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_dv === 1'b1) dv_cnt = dv_cnt + 1;
        if (burst_done === 1'b1) bd_cnt = bd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_dv(output int t);
        t = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_dv === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check("dv_timeout", 0, 1);
    endtask

    task automatic wait_bd(output int t);
        t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (burst_done === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check("burst_done_timeout", 0, 1);
    endtask

    // kind: 0 correct echo, 1 corrupted echo (0xFF), 2 no echo
    task automatic pulse_done(input int kind);
        repeat (10) @(negedge clk);
        tx_done = 1'b1;
        last_m  = cyc;
        @(negedge clk);
        tx_done = 1'b0;
        rx_data = (kind == 1) ? 8'hFF : tx_data;
`ifdef RX_ECHO_CHECK_EN
        if (kind != 2) begin
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
        end
`endif
    endtask

    task automatic run_burst(input logic [1:0] m, input logic [7:0] s, input int n, input int stop_word,
                             input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp_w [4];
        int t, n0, dv0, bd0;
        exp_w = '{e0, e1, e2, e3};
        dv0 = dv_cnt;
        bd0 = bd_cnt;
        @(negedge clk);
        mode  = m;
        seed  = s;
        start = 1'b1;
        n0    = cyc;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        for (int i = 0; i < n; i++) begin
            wait_dv(t);
            check("dv_cycle", t, (i == 0) ? n0 + 2 : last_m + GAP + 2 + ECHO_LAT);
            check("tx_data", 32'(tx_data), 32'(exp_w[i]));
            if (i + 1 == stop_word) stop = 1'b1;
            pulse_done(0);
        end
        wait_bd(t);
        check("burst_done_cycle", t, last_m + GAP + 1 + ECHO_LAT);
        check("word_cnt_final", 32'(word_cnt), n);
        check("err_cnt_clean", 32'(err_cnt), 0);
        stop = 1'b0;
        repeat (20) @(negedge clk);
        check("dv_count", dv_cnt - dv0, n);
        check("burst_done_count", bd_cnt - bd0, 1);
        check("busy_idle", 32'(busy), 0);
    endtask

    initial begin
        int t;
        int bd0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_dv", 32'(tx_dv), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_burst_done", 32'(burst_done), 0);
        check("rst_word_cnt", 32'(word_cnt), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        rst = 1'b0;

        run_burst(2'd0, 8'hFE, 4, 0, 8'hFE, 8'hFF, 8'h00, 8'h01);
        check("tx_data_after_inc", 32'(tx_data), 32'h02);

        run_burst(2'd3, 8'h00, 3, 3, 8'h01, 8'hB8, 8'h5C, 8'h00);

        run_burst(2'd2, 8'h80, 2, 2, 8'h80, 8'h01, 8'h00, 8'h00);

        bd0 = bd_cnt;
        @(negedge clk);
        mode  = 2'd0;
        seed  = 8'h10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_dv(t);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_tx_dv", 32'(tx_dv), 0);
        check("midrst_word_cnt", 32'(word_cnt), 0);
        check("midrst_tx_data", 32'(tx_data), 0);
        repeat (15) @(negedge clk);
        check("midrst_no_burst_done", bd_cnt - bd0, 0);
        check("midrst_stays_idle", 32'(busy), 0);

        run_burst(2'd1, 8'h01, 4, 0, 8'h01, 8'h00, 8'hFF, 8'hFE);

`ifdef RX_ECHO_CHECK_EN
        @(negedge clk);
        mode  = 2'd0;
        seed  = 8'h02;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_dv(t);
        check("echo_word0", 32'(tx_data), 32'h02);
        pulse_done(1);
        wait_dv(t);
        check("echo_mismatch_err", 32'(err_cnt), 1);
        stop = 1'b1;
        pulse_done(2);
        wait_bd(t);
        check("echo_timeout_err", 32'(err_cnt), 2);
        check("echo_word_cnt", 32'(word_cnt), 2);
        stop = 1'b0;
        repeat (5) @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
